// File: rtl/vga_timing_gen_if.sv
// Request/colour/sync bundle between vga_timing_gen and its renderer and DAC neighbours.
// pattern_sel exists only when TESTPATTERN_EN is defined.
interface vga_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int CW = 8
) ();
  logic          pix_ce;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_req;
  logic [3*CW-1:0] rgb_in;
`ifdef TESTPATTERN_EN
  logic          pattern_sel;
`endif
  logic          vga_HS;
  logic          vga_VS;
  logic [CW-1:0] R;
  logic [CW-1:0] G;
  logic [CW-1:0] B;
  logic          line_start;
  logic          frame_start;

  modport master (
`ifdef TESTPATTERN_EN
    input  pattern_sel,
`endif
    input  rgb_in,
    output pix_ce, pix_x, pix_y, pix_req,
    output vga_HS, vga_VS, R, G, B, line_start, frame_start
  );

  modport slave (
`ifdef TESTPATTERN_EN
    output pattern_sel,
`endif
    output rgb_in,
    input  pix_ce, pix_x, pix_y, pix_req,
    input  vga_HS, vga_VS, R, G, B, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock enable, H/V counters, one-pixel request->output pipeline.
// Optional TESTPATTERN_EN adds pattern_sel and an 8-bar colour test pattern.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;

  function automatic logic sync_lvl(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

  function automatic logic [3*CW-1:0] blank_rgb(input logic req, input logic [3*CW-1:0] rgb);
    return req ? rgb : '0;
  endfunction

`ifdef TESTPATTERN_EN
  localparam logic [XW-1:0] BAR_W = XW'(H_ACTIVE / 8);

  // Bar order white..black is the 3-bit index inverted and routed as {G,R,B} = ~index.
  function automatic logic [3*CW-1:0] bar_rgb(input logic [2:0] bar);
    return {{CW{~bar[1]}}, {CW{~bar[2]}}, {CW{~bar[0]}}};
  endfunction
`endif

  logic            pix_ce;
  logic [XW-1:0]   x_p0;
  logic [YW-1:0]   y_p0;
  logic            req_p0;
  logic            hs_act_p0;
  logic            vs_act_p0;
  logic [3*CW-1:0] rgb_p0;
  logic            hs_p1;
  logic            vs_p1;
  logic [3*CW-1:0] rgb_p1;
  logic            line_p1;
  logic            frame_p1;

  generate
    if (CLK_DIV > 1) begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
      logic [DW-1:0] div_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  div_cnt <= '0;
        else if (div_cnt == DIV_LAST) div_cnt <= '0;
        else                         div_cnt <= div_cnt + DW'(1);
      end

      assign pix_ce = (div_cnt == DIV_LAST);
    end else begin : g_nodiv
      assign pix_ce = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_p0 <= '0;
      y_p0 <= '0;
    end else if (pix_ce) begin
      if (x_p0 == X_LAST) begin
        x_p0 <= '0;
        y_p0 <= (y_p0 == Y_LAST) ? '0 : y_p0 + YW'(1);
      end else begin
        x_p0 <= x_p0 + XW'(1);
      end
    end
  end

  // request stage (p0): combinational from the counters, colour returned in the same cycle
  assign req_p0    = (int'(x_p0) < H_ACTIVE) && (int'(y_p0) < V_ACTIVE);
  assign hs_act_p0 = (int'(x_p0) >= HS_BEG) && (int'(x_p0) < HS_END);
  assign vs_act_p0 = (int'(y_p0) >= VS_BEG) && (int'(y_p0) < VS_END);

  always_comb begin
    rgb_p0 = vif.rgb_in;
`ifdef TESTPATTERN_EN
    if (vif.pattern_sel) rgb_p0 = bar_rgb(3'(x_p0 / BAR_W));
`endif
    rgb_p0 = blank_rgb(req_p0, rgb_p0);
  end

  // output stage (p1): sync and colour captured together on pix_ce
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p1    <= ~HS_POL;
      vs_p1    <= ~VS_POL;
      rgb_p1   <= '0;
      line_p1  <= 1'b0;
      frame_p1 <= 1'b0;
    end else begin
      line_p1  <= pix_ce && (x_p0 == '0);
      frame_p1 <= pix_ce && (x_p0 == '0) && (y_p0 == '0);
      if (pix_ce) begin
        hs_p1  <= sync_lvl(hs_act_p0, HS_POL);
        vs_p1  <= sync_lvl(vs_act_p0, VS_POL);
        rgb_p1 <= rgb_p0;
      end
    end
  end

  assign vif.pix_ce      = pix_ce;
  assign vif.pix_x       = x_p0;
  assign vif.pix_y       = y_p0;
  assign vif.pix_req     = req_p0;
  assign vif.vga_HS      = hs_p1;
  assign vif.vga_VS      = vs_p1;
  assign vif.R           = rgb_p1[3*CW-1:2*CW];
  assign vif.G           = rgb_p1[2*CW-1:CW];
  assign vif.B           = rgb_p1[CW-1:0];
  assign vif.line_start  = line_p1;
  assign vif.frame_start = frame_p1;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: shortened-frame instance with scoreboarded pixels and sync timing,
// plus a tiny CLK_DIV=1 / positive-polarity instance for sync width and period.
module tb_vga_timing_gen;
  localparam int HA = 640, HF = 16, HSW = 96, HB = 48;
  localparam int VA = 22,  VF = 1,  VSW = 2,  VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.XW(10), .YW(5), .CW(8)) bus ();
  vga_timing_gen_if #(.XW(4),  .YW(3), .CW(8)) sm ();

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(8)
  ) u_dut (.clk(clk), .rst_n(rst_n), .vif(bus));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(8)
  ) u_small (.clk(clk), .rst_n(rst_n), .vif(sm));

  bit pat_on;
  assign bus.rgb_in = {8'(bus.pix_x), 8'(bus.pix_y), 8'hA5};
  assign sm.rgb_in  = 24'h5A3CC3;
`ifdef TESTPATTERN_EN
  assign bus.pattern_sel = pat_on;
  assign sm.pattern_sel  = 1'b0;
`endif

  typedef struct {
    int         idx;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       ls;
    logic       fs;
  } exp_t;

  exp_t sb[$];
  int   n;
  int   vec_cnt;
  int   err_cnt;

  // Sync pulse measurement: index 0 main HS, 1 main VS, 2 small HS, 3 small VS (asserted level).
  logic [3:0]  act;
  logic [3:0]  act_q;
  int unsigned cyc;
  int unsigned a_start  [4];
  int unsigned a_width  [4];
  int unsigned a_period [4];
  bit          a_seen   [4];
  assign act = {sm.vga_VS, sm.vga_HS, ~bus.vga_VS, ~bus.vga_HS};

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) a_seen[i] = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (act[i] && !act_q[i]) begin
          if (a_seen[i]) a_period[i] = cyc - a_start[i];
          a_start[i] = cyc;
          a_seen[i]  = 1'b1;
        end else if (!act[i] && act_q[i] && a_seen[i]) begin
          a_width[i] = cyc - a_start[i];
        end
      end
    end
    act_q = act;
  end

  function automatic logic [2:0] bar_colour(input int bar);
    case (bar)
      0:       return 3'b111;
      1:       return 3'b110;
      2:       return 3'b011;
      3:       return 3'b010;
      4:       return 3'b101;
      5:       return 3'b100;
      6:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic exp_t model(input int idx);
    exp_t       e;
    int         x;
    int         y;
    logic [2:0] c;
    x = idx % HT;
    y = (idx / HT) % VT;
    e.idx = idx;
    e.hs  = !(x >= HA + HF && x < HA + HF + HSW);
    e.vs  = !(y >= VA + VF && y < VA + VF + VSW);
    e.ls  = (x == 0);
    e.fs  = (x == 0) && (y == 0);
    e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
    if (x < HA && y < VA) begin
      if (pat_on) begin
        c   = bar_colour(x / (HA / 8));
        e.r = {8{c[2]}};
        e.g = {8{c[1]}};
        e.b = {8{c[0]}};
      end else begin
        e.r = 8'(x);
        e.g = 8'(y);
        e.b = 8'hA5;
      end
    end
    return e;
  endfunction

  function automatic bit tracked(input int idx);
    case (idx % HT)
      0, 1, 9, 10, 11, 79, 80, 81, 159, 160, 239, 240, 299, 319, 320, 399, 400,
      479, 480, 559, 560, 638, 639, 640, 641, 655, 656, 700, 751, 752, 798, 799:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s px=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_request();
    exp_t e;
    int   x;
    int   y;
    if (!tracked(n)) return;
    x = n % HT;
    y = (n / HT) % VT;
    e = model(n);
    chk("pix_x",      32'(bus.pix_x),       x);
    chk("pix_y",      32'(bus.pix_y),       y);
    chk("pix_req",    32'(bus.pix_req),     32'(x < HA && y < VA));
    chk("pix_ce_req", 32'(bus.pix_ce),      32'd1);
    chk("line_low",   32'(bus.line_start),  32'd0);
    chk("frame_low",  32'(bus.frame_start), 32'd0);
    sb.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0 || sb[0].idx != n) return;
    e = sb.pop_front();
    chk("vga_HS",      32'(bus.vga_HS),      32'(e.hs));
    chk("vga_VS",      32'(bus.vga_VS),      32'(e.vs));
    chk("R",           32'(bus.R),           32'(e.r));
    chk("G",           32'(bus.G),           32'(e.g));
    chk("B",           32'(bus.B),           32'(e.b));
    chk("line_start",  32'(bus.line_start),  32'(e.ls));
    chk("frame_start", 32'(bus.frame_start), 32'(e.fs));
    chk("pix_ce_gap",  32'(bus.pix_ce),      32'd0);
  endtask

  // Advance from the request of pixel n to the request of pixel n+1.
  task automatic step_px();
    @(posedge clk); #1;
    check_output();
    n++;
    @(posedge clk); #1;
    check_request();
  endtask

  task automatic run_to(input int target);
    while (n < target) step_px();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    sb.delete();
    @(posedge clk); #1;
    check_request();
  endtask

  initial begin
    rst_n   = 1'b0;
    pat_on  = 1'b0;
    n       = 0;
    vec_cnt = 0;
    err_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_HS",    32'(bus.vga_HS),      32'd1);
    chk("rst_VS",    32'(bus.vga_VS),      32'd1);
    chk("rst_R",     32'(bus.R),           32'd0);
    chk("rst_G",     32'(bus.G),           32'd0);
    chk("rst_B",     32'(bus.B),           32'd0);
    chk("rst_line",  32'(bus.line_start),  32'd0);
    chk("rst_frame", 32'(bus.frame_start), 32'd0);
    chk("rst_x",     32'(bus.pix_x),       32'd0);
    chk("rst_y",     32'(bus.pix_y),       32'd0);
    chk("rst_ce",    32'(bus.pix_ce),      32'd0);
    chk("rst_sm_HS", 32'(sm.vga_HS),       32'd0);
    chk("rst_sm_VS", 32'(sm.vga_VS),       32'd0);

    release_rst();
    run_to(HT * VT + 2 * HT + 300);

    chk("HS_period",    a_period[0], 32'd1600);
    chk("HS_low",       a_width[0],  32'd192);
    chk("VS_low",       a_width[1],  32'd3200);
    chk("sm_HS_high",   a_width[2],  32'd3);
    chk("sm_HS_period", a_period[2], 32'd14);
    chk("sm_VS_high",   a_width[3],  32'd14);
    chk("sm_VS_period", a_period[3], 32'd98);
    chk("sm_pix_ce",    32'(sm.pix_ce), 32'd1);

    // asynchronous reset in the middle of an active line
    #2 rst_n = 1'b0;
    #1;
    chk("arst_HS", 32'(bus.vga_HS), 32'd1);
    chk("arst_VS", 32'(bus.vga_VS), 32'd1);
    chk("arst_R",  32'(bus.R),      32'd0);
    chk("arst_G",  32'(bus.G),      32'd0);
    chk("arst_B",  32'(bus.B),      32'd0);
    chk("arst_x",  32'(bus.pix_x),  32'd0);
    chk("arst_y",  32'(bus.pix_y),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_line",  32'(bus.line_start),  32'd0);
    chk("arst_frame", 32'(bus.frame_start), 32'd0);
    chk("arst_ce",    32'(bus.pix_ce),      32'd0);

`ifdef TESTPATTERN_EN
    pat_on = 1'b1;
`endif
    release_rst();
    run_to(HT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
